// File: rtl/rob_seq_ctrl.sv
// Reorder-buffer sequencing controller: allocates entries in order at the tail,
// tracks completion per entry, and retires finished entries in order from the head.
module rob_seq_ctrl #(
  parameter int ROBsize  = 16,
  parameter int addrSize = $clog2(ROBsize)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                dispatch_valid_i,
  output logic                dispatch_ready_o,
  output logic [addrSize-1:0] dispatch_tag_o,
  input  logic                complete_valid_i,
  input  logic [addrSize-1:0] complete_tag_i,
  output logic                commit_valid_o,
  output logic [addrSize-1:0] commit_tag_o,
  input  logic                commit_ready_i,
  input  logic                flush_i,
  output logic [addrSize:0]   count_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                state_o
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high at the rising edge; ready never depends combinationally on valid.

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [addrSize:0]   FULL_COUNT = (addrSize+1)'(ROBsize);
  localparam logic [addrSize-1:0] IDX_ONE    = addrSize'(1);
  localparam logic [addrSize:0]   CNT_ONE    = (addrSize+1)'(1);

  state_t              state_q, state_d;
  logic [addrSize-1:0] head_q, tail_q;
  logic [addrSize:0]   count_q;
  logic [ROBsize-1:0]  alloc_q, done_q;
  logic                dispatch_fire, commit_fire, complete_hit;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= RUN;
    else            state_q <= state_d;
  end

  // FLUSH lasts exactly one cycle unless flush_i stays high.
  always_comb begin
    state_d = RUN;
    if (flush_i) state_d = FLUSH;
  end

  always_comb begin
    full_o           = (count_q == FULL_COUNT);
    empty_o          = (count_q == '0);
    count_o          = count_q;
    dispatch_ready_o = (state_q == RUN) && !full_o;
    dispatch_tag_o   = tail_q;
    commit_valid_o   = (state_q == RUN) && alloc_q[head_q] && done_q[head_q];
    commit_tag_o     = head_q;
    state_o          = state_q;
  end

  assign dispatch_fire = dispatch_valid_i && dispatch_ready_o;
  assign commit_fire   = commit_valid_o && commit_ready_i;
  assign complete_hit  = (state_q == RUN) && complete_valid_i && alloc_q[complete_tag_i];

  // Commit is applied after completion so a retiring head always ends up clear.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      alloc_q <= '0;
      done_q  <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      alloc_q <= '0;
      done_q  <= '0;
    end else begin
      if (dispatch_fire) begin
        alloc_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + IDX_ONE;
      end
      if (complete_hit) begin
        done_q[complete_tag_i] <= 1'b1;
      end
      if (commit_fire) begin
        alloc_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
        head_q          <= head_q + IDX_ONE;
      end
      case ({dispatch_fire, commit_fire})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: doc/rob_seq_ctrl.md
ROB_SEQ_CTRL -- requirements
Module: rob_seq_ctrl

Interface
REQ-001 SHALL have parameter ROBsize, default 16, number of ROB entries (power of two, >=4).
REQ-002 SHALL have parameter addrSize, default $clog2(ROBsize), entry index width.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port dispatch_valid_i  input  1  dispatch requests one ROB entry.
REQ-006 SHALL have port dispatch_ready_o  output  1  controller can accept a dispatch this cycle.
REQ-007 SHALL have port dispatch_tag_o  output  addrSize  index allocated on a dispatch fire (current tail).
REQ-008 SHALL have port complete_valid_i  input  1  an execution unit reports an entry finished.
REQ-009 SHALL have port complete_tag_i  input  addrSize  index of the finished entry.
REQ-010 SHALL have port commit_valid_o  output  1  head entry is finished and may retire.
REQ-011 SHALL have port commit_tag_o  output  addrSize  index of head entry.
REQ-012 SHALL have port commit_ready_i  input  1  retire stage accepts the head entry.
REQ-013 SHALL have port flush_i  input  1  discard all in-flight entries (mispredict/exception).
REQ-014 SHALL have port count_o  output  addrSize+1  occupied entries, 0..ROBsize.
REQ-015 SHALL have ports full_o / empty_o  output  1 each  count_o==ROBsize / count_o==0.

Function
REQ-016 SHALL keep registers head, tail (addrSize bits, wrap modulo ROBsize), count (addrSize+1), alloc[ROBsize], done[ROBsize], state {RUN, FLUSH}.
REQ-017 SHALL use all ROBsize entries; full distinguished from empty by count, not by head/tail equality.
REQ-018 Dispatch fire = dispatch_valid_i & dispatch_ready_o; dispatch_ready_o = (state==RUN) & ~full_o, no same-cycle bypass from a commit.
REQ-019 On dispatch fire: alloc[tail]<=1, done[tail]<=0, tail<=tail+1 (wraps ROBsize-1 -> 0); dispatch_tag_o = tail combinationally.
REQ-020 On complete_valid_i with alloc[complete_tag_i]==1: done[complete_tag_i]<=1; completion to an unallocated entry SHALL be ignored; repeated completion harmless.
REQ-021 commit_valid_o = (state==RUN) & alloc[head] & done[head]; commit_tag_o = head always.
REQ-022 Commit fire = commit_valid_o & commit_ready_i: alloc[head]<=0, done[head]<=0, head<=head+1 (wraps).
REQ-023 A completion registered in cycle N for the head entry SHALL raise commit_valid_o in cycle N+1 (one-cycle latency, no combinational path complete->commit).
REQ-024 count: +1 on dispatch fire only, -1 on commit fire only, unchanged when both fire in the same cycle.
REQ-025 Simultaneous dispatch and commit on a full ROB: dispatch not accepted (ready=0), commit proceeds, count ROBsize-1 next cycle.
REQ-026 commit_valid_o SHALL never assert while empty_o=1; count SHALL never exceed ROBsize nor underflow.
REQ-027 FSM: RUN --flush_i--> FLUSH; FLUSH --unconditional, 1 cycle--> RUN; flush_i held high keeps state FLUSH.
REQ-028 On flush_i (any state): next cycle head=tail=0, count=0, all alloc/done=0; flush SHALL take priority over same-cycle dispatch, complete and commit (none take effect).
REQ-029 In FLUSH: dispatch_ready_o=0, commit_valid_o=0; completions ignored.

Reset
REQ-030 While reset_n_i=0 (asynchronously, including mid-operation): state=RUN, head=tail=0, count=0, alloc=done=0; outputs dispatch_ready_o=1, dispatch_tag_o=0, commit_valid_o=0, commit_tag_o=0, count_o=0, full_o=0, empty_o=1.
REQ-031 Deassertion of reset_n_i SHALL be usable on any clock edge; first dispatch accepted on the first rising edge after release.

Verification (ROBsize=4)
REQ-032 Reset, dispatch 4 back-to-back -> tags 0,1,2,3; count_o=4, full_o=1, dispatch_ready_o=0; 5th request not accepted, tail stays 0.
REQ-033 Complete tags 2 then 0, commit_ready_i=1 -> commit_valid_o rises cycle after tag 0 completes; tag 0 retires, then commit_valid_o=0 (head=1 not done); count_o=3.
REQ-034 Full ROB, head done, dispatch_valid_i=1 and commit_ready_i=1 same cycle -> commit only, count_o=3; next cycle dispatch accepted with tag 0 (wrap), count_o=4.
REQ-035 Complete_tag_i=3 while entry 3 unallocated -> no change; later dispatch of entry 3 shows done[3]=0, no spurious commit.
REQ-036 3 entries in flight, flush_i with simultaneous dispatch/complete/commit -> one FLUSH cycle (ready=0, commit_valid=0), then count_o=0, empty_o=1, next dispatch tag 0.
REQ-037 reset_n_i pulsed low between clock edges with 2 entries in flight -> outputs reach reset values immediately, before next edge.
